// File: rtl/mfcc_pkg.sv
// mfcc_pkg: shared coefficient type, sync default and packer states; MFCC_PACKER_CHECKSUM_EN adds the CSUM state
package mfcc_pkg;
  localparam int COEF_W = 16;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  typedef logic [COEF_W-1:0] mfcc_data_t;
`ifdef MFCC_PACKER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, SYNC, SEQ, DATA, CSUM} packer_state_e;
`else
  typedef enum logic [1:0] {IDLE, SYNC, SEQ, DATA} packer_state_e;
`endif
endpackage

// File: rtl/mfcc_frame_packer_if.sv
// mfcc_frame_packer_if: coefficient input and byte-stream output bundle of the frame packer
interface mfcc_frame_packer_if #(parameter int NUM_COEFFICIENTS = 12);
  import mfcc_pkg::*;
  logic mfcc_done_i;
  mfcc_data_t mfcc_data_i [0:NUM_COEFFICIENTS-1];
  logic [7:0] tx_data_o;
  logic tx_valid_o;
  logic tx_ready_i;
  logic busy_o;
  logic [7:0] drop_count_o;
  modport master (output mfcc_done_i, mfcc_data_i, tx_ready_i, input tx_data_o, tx_valid_o, busy_o, drop_count_o);
  modport slave (input mfcc_done_i, mfcc_data_i, tx_ready_i, output tx_data_o, tx_valid_o, busy_o, drop_count_o);
endinterface

// File: rtl/mfcc_frame_packer.sv
// mfcc_frame_packer: serialises a coefficient frame into SYNC/SEQ/data bytes (checksum byte with MFCC_PACKER_CHECKSUM_EN)
module mfcc_frame_packer
  import mfcc_pkg::*;
#(
  parameter int NUM_COEFFICIENTS = 12,
  parameter int COEF_WIDTH = 16,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input logic clk,
  input logic rst,
  mfcc_frame_packer_if.slave bus
);
  localparam int CW = $clog2(NUM_COEFFICIENTS);
  localparam int IW = CW + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(2 * NUM_COEFFICIENTS - 1);
  packer_state_e state_q, state_d, after_data;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0] seq_q, seq_d, drop_q, drop_d, byte_sel, tail;
  mfcc_data_t shadow_q [0:NUM_COEFFICIENTS-1];
  mfcc_data_t shadow_d [0:NUM_COEFFICIENTS-1];
  logic [COEF_WIDTH-1:0] coef;
  logic valid, hs, data_end, last, accept;
`ifdef MFCC_PACKER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
`endif
  // handshake decode, byte mux and next-state computation
  always_comb begin
    valid = state_q != IDLE;
    hs = valid && bus.tx_ready_i;
    data_end = state_q == DATA && idx_q == LAST_IDX;
`ifdef MFCC_PACKER_CHECKSUM_EN
    last = state_q == CSUM;
    after_data = data_end ? CSUM : state_q;
    tail = state_q == CSUM ? csum_q : 8'h00;
`else
    last = data_end;
    after_data = state_q;
    tail = 8'h00;
`endif
    accept = bus.mfcc_done_i && (!valid || (hs && last));
    coef = shadow_q[idx_q[IW-1:1]];
    byte_sel = state_q == SYNC ? SYNC_BYTE :
               state_q == SEQ ? seq_q :
               state_q == DATA ? (idx_q[0] ? coef[7:0] : coef[COEF_WIDTH-1 -: 8]) : tail;
    state_d = accept ? SYNC :
              !hs ? state_q :
              state_q == SYNC ? SEQ :
              state_q == SEQ ? DATA :
              last ? IDLE : after_data;
    idx_d = accept ? '0 : (hs && state_q == DATA && !data_end) ? idx_q + 1'b1 : idx_q;
    seq_d = hs && last ? seq_q + 8'd1 : seq_q;
    drop_d = bus.mfcc_done_i && !accept && drop_q != 8'hFF ? drop_q + 8'd1 : drop_q;
    shadow_d = accept ? bus.mfcc_data_i : shadow_q;
`ifdef MFCC_PACKER_CHECKSUM_EN
    csum_d = !hs ? csum_q : state_q == SYNC ? SYNC_BYTE : csum_q ^ byte_sel;
`endif
  end
  // state, counters and shadow registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      seq_q <= '0;
      drop_q <= '0;
      shadow_q <= '{default: '0};
`ifdef MFCC_PACKER_CHECKSUM_EN
      csum_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      seq_q <= seq_d;
      drop_q <= drop_d;
      shadow_q <= shadow_d;
`ifdef MFCC_PACKER_CHECKSUM_EN
      csum_q <= csum_d;
`endif
    end
  end
  assign bus.tx_valid_o = valid;
  assign bus.busy_o = valid;
  assign bus.tx_data_o = byte_sel;
  assign bus.drop_count_o = drop_q;
endmodule

// File: tb/tb_mfcc_frame_packer.sv
// tb_mfcc_frame_packer: table vectors, corner sequences and random traffic against a packet-level reference model
module tb_mfcc_frame_packer;
  import mfcc_pkg::*;
  localparam int N = 12;
`ifdef MFCC_PACKER_CHECKSUM_EN
  localparam int PLEN = 2 * N + 3;
`else
  localparam int PLEN = 2 * N + 2;
`endif
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  mfcc_frame_packer_if #(.NUM_COEFFICIENTS(N)) bus ();
  mfcc_frame_packer #(.NUM_COEFFICIENTS(N)) dut (.clk(clk), .rst(rst), .bus(bus));
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ready_mode = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] m_seq = 8'h00;
  logic [7:0] m_drop = 8'h00;
  mfcc_data_t coefs [N];
  typedef struct {
    logic [15:0] base;
    logic [15:0] step;
    int mode;
    logic [7:0] seq;
    logic [7:0] first_msb;
    logic [7:0] last_lsb;
  } vec_t;
  vec_t tbl [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // expected packet: sync, sequence, each coefficient MSB then LSB, optional XOR of all earlier bytes
  function automatic void push_packet(input logic [7:0] seq, input mfcc_data_t c [N]);
    logic [7:0] x;
    exp_q.push_back(SYNC_BYTE_DEFAULT);
    exp_q.push_back(seq);
    for (int k = 0; k < N; k++) begin
      exp_q.push_back(c[k][15:8]);
      exp_q.push_back(c[k][7:0]);
    end
    x = 8'h00;
    foreach (exp_q[i]) x ^= exp_q[i];
`ifdef MFCC_PACKER_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endfunction

  // one clock: drive inputs at negedge, compare outputs with the model, advance the model across the next edge
  task automatic cycle(input bit done, input bit r);
    @(negedge clk);
    cyc++;
    bus.tx_ready_i = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? cyc[0] :
                     ready_mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
    bus.mfcc_done_i = done;
    rst = r;
    for (int k = 0; k < N; k++) bus.mfcc_data_i[k] = done ? coefs[k] : mfcc_data_t'($urandom);
    check("valid", 32'(bus.tx_valid_o), 32'(exp_q.size() > 0));
    check("busy", 32'(bus.busy_o), 32'(exp_q.size() > 0));
    check("drop_count", 32'(bus.drop_count_o), 32'(m_drop));
    if (exp_q.size() > 0) check("tx_data", 32'(bus.tx_data_o), 32'(exp_q[0]));
    if (r) begin
      exp_q.delete();
      m_seq = 8'h00;
      m_drop = 8'h00;
    end else begin
      if (bus.tx_ready_i && exp_q.size() > 0) begin
        got_q.push_back(bus.tx_data_o);
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) m_seq++;
      end
      if (done) begin
        if (exp_q.size() == 0) push_packet(m_seq, coefs);
        else if (m_drop != 8'hFF) m_drop++;
      end
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      cycle(1'b0, 1'b0);
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d bytes still pending, expected 0", exp_q.size());
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl = '{'{16'h0100, 16'h0001, 0, 8'h00, 8'h01, 8'h0B},
            '{16'h0100, 16'h0001, 1, 8'h01, 8'h01, 8'h0B},
            '{16'hFFFF, 16'h0000, 2, 8'h02, 8'hFF, 8'hFF},
            '{16'h1234, 16'h1111, 0, 8'h03, 8'h12, 8'hEF}};
    rst = 1'b1;
    bus.mfcc_done_i = 1'b0;
    bus.tx_ready_i = 1'b1;
    for (int k = 0; k < N; k++) bus.mfcc_data_i[k] = '0;
    repeat (2) @(posedge clk);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    check("rst_valid", 32'(bus.tx_valid_o), 32'd0);
    check("rst_data", 32'(bus.tx_data_o), 32'd0);
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_drop", 32'(bus.drop_count_o), 32'd0);
    foreach (tbl[t]) begin
      ready_mode = tbl[t].mode;
      for (int k = 0; k < N; k++) coefs[k] = tbl[t].base + 16'(k) * tbl[t].step;
      got_q.delete();
      cycle(1'b1, 1'b0);
      drain(400);
      cycle(1'b0, 1'b0);
      check("tbl_len", 32'(got_q.size()), 32'(PLEN));
      check("tbl_sync", 32'(got_q[0]), 32'hA5);
      check("tbl_seq", 32'(got_q[1]), 32'(tbl[t].seq));
      check("tbl_first_msb", 32'(got_q[2]), 32'(tbl[t].first_msb));
      check("tbl_last_lsb", 32'(got_q[2 * N + 1]), 32'(tbl[t].last_lsb));
    end
    ready_mode = 0;
    for (int k = 0; k < N; k++) coefs[k] = 16'h0100 + 16'(k);
    got_q.delete();
    cycle(1'b1, 1'b0);
    repeat (5) cycle(1'b0, 1'b0);
    for (int k = 0; k < N; k++) coefs[k] = 16'hDEAD;
    cycle(1'b1, 1'b0);
    drain(400);
    cycle(1'b0, 1'b0);
    check("drop_one", 32'(bus.drop_count_o), 32'd1);
    check("drop_pkt_coef1", 32'(got_q[4]), 32'h01);
    ready_mode = 3;
    cycle(1'b1, 1'b0);
    repeat (300) cycle(1'b1, 1'b0);
    ready_mode = 0;
    drain(400);
    cycle(1'b0, 1'b0);
    check("drop_sat", 32'(bus.drop_count_o), 32'd255);
    got_q.delete();
    cycle(1'b1, 1'b0);
    while (got_q.size() < 10 && exp_q.size() > 0) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b0);
    check("midrst_valid", 32'(bus.tx_valid_o), 32'd0);
    check("midrst_drop", 32'(bus.drop_count_o), 32'd0);
    got_q.delete();
    cycle(1'b1, 1'b0);
    drain(400);
    cycle(1'b0, 1'b0);
    check("midrst_seq", 32'(got_q[1]), 32'h00);
    cycle(1'b0, 1'b1);
    for (int k = 0; k < N; k++) coefs[k] = 16'h0100 + 16'(k);
    cycle(1'b1, 1'b0);
    while (exp_q.size() > 1) cycle(1'b0, 1'b0);
    for (int k = 0; k < N; k++) coefs[k] = 16'h0200 + 16'(k);
    got_q.delete();
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    check("b2b_last", 32'(got_q[0]), 32'h0B);
    check("b2b_sync", 32'(got_q[1]), 32'hA5);
    check("b2b_seq", 32'(got_q[2]), 32'h01);
    drain(400);
    cycle(1'b0, 1'b0);
`ifdef MFCC_PACKER_CHECKSUM_EN
    cycle(1'b0, 1'b1);
    for (int k = 0; k < N; k++) coefs[k] = '0;
    got_q.delete();
    cycle(1'b1, 1'b0);
    drain(400);
    cycle(1'b0, 1'b0);
    check("csum_len", 32'(got_q.size()), 32'd27);
    check("csum_byte", 32'(got_q[26]), 32'hA5);
`endif
    ready_mode = 2;
    repeat (800) begin
      for (int k = 0; k < N; k++) coefs[k] = mfcc_data_t'($urandom);
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 199) == 0);
    end
    ready_mode = 0;
    drain(400);
    cycle(1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mfcc_frame_packer.md
MFCC_FRAME_PACKER -- requirements
Module: mfcc_frame_packer

Interface
REQ-001 SHALL have parameter NUM_COEFFICIENTS, default 12, coefficients per frame.
REQ-002 SHALL have parameter COEF_WIDTH, default 16, bits per coefficient; only 16 supported.
REQ-003 SHALL have parameter SYNC_BYTE, default 8'hA5, first byte of every packet.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port mfcc_done_i  input  1  one-cycle pulse: coefficient set valid.
REQ-007 SHALL have port mfcc_data_i  input  mfcc_data_t [0:NUM_COEFFICIENTS-1]  coefficient array, sampled on accepted mfcc_done_i.
REQ-008 SHALL have port tx_data_o  output  8  packet byte.
REQ-009 SHALL have port tx_valid_o  output  1  tx_data_o valid.
REQ-010 SHALL have port tx_ready_i  input  1  downstream accepts byte when high with tx_valid_o.
REQ-011 SHALL have port busy_o  output  1  packet in flight.
REQ-012 SHALL have port drop_count_o  output  8  saturating count of dropped frames.

Function
REQ-013 Packet SHALL be: SYNC_BYTE, 8-bit sequence number, then coefficients 0..N-1, each MSB byte then LSB byte (2+2N bytes; 26 at default).
REQ-014 FSM states SHALL be IDLE, SYNC, SEQ, DATA (and CSUM when enabled); IDLE->SYNC on accepted done; SYNC->SEQ->DATA on each handshake; DATA exits after byte 2N-1 handshake.
REQ-015 Accepted mfcc_done_i SHALL snapshot all coefficients into a shadow register in the same edge; later mfcc_data_i changes SHALL not affect the packet.
REQ-016 tx_valid_o SHALL assert on the cycle after an accepted mfcc_done_i (1-cycle latency).
REQ-017 Byte advances only on tx_valid_o && tx_ready_i; while tx_valid_o && !tx_ready_i, tx_data_o SHALL hold stable and tx_valid_o SHALL not drop.
REQ-018 mfcc_done_i SHALL be accepted in IDLE or in the cycle the final packet byte completes its handshake; the latter starts the next packet back-to-back with no idle cycle.
REQ-019 mfcc_done_i at any other time SHALL be dropped: shadow and packet unaffected, drop_count_o increments, saturating at 255.
REQ-020 Sequence number SHALL start at 0 and increment by 1 (mod 256) per packet whose final byte is accepted.
REQ-021 busy_o SHALL be high in every state except IDLE.
REQ-022 Byte index counter SHALL cover 0..2N-1 and reset to 0 on each packet start.

Reset
REQ-023 On rst high at a clk edge: state IDLE, tx_valid_o 0, tx_data_o 0, busy_o 0, drop_count_o 0, sequence 0, byte index 0, shadow 0.
REQ-024 Reset mid-packet SHALL abort the packet with no further bytes; mfcc_done_i in a reset cycle SHALL be ignored and not counted.

Configuration
REQ-025 Macro MFCC_PACKER_CHECKSUM_EN defined: CSUM state appends one byte = XOR of all preceding packet bytes including SYNC and SEQ; packet = 2N+3 bytes; final byte for REQ-018/REQ-020 is the checksum.
REQ-026 Macro undefined: no CSUM state or XOR logic; packet = 2N+2 bytes.

Structure
REQ-027 mfcc_data_t, SYNC_BYTE default and the packer state enum SHALL reside in shared package mfcc_pkg.
REQ-028 No sub-module; single module with FSM, shadow register, byte mux and counters.

Verification
REQ-029 Done with coef[k]=16'h0100+k, tx_ready_i=1 -> bytes A5,00,01,00,01,01,...,01,0B on consecutive cycles, first valid 1 cycle after done, busy_o low after last.
REQ-030 Same frame, tx_ready_i toggling 1/0 each cycle -> identical byte sequence, tx_data_o stable in every stalled cycle.
REQ-031 Second done mid-packet -> packet unchanged, drop_count_o=1; 300 such drops -> drop_count_o=255.
REQ-032 Done coincident with final-byte handshake -> next packet SYNC on next cycle, sequence byte 01.
REQ-033 rst asserted at byte 10 -> tx_valid_o 0 next cycle, next packet has sequence 00.
REQ-034 MFCC_PACKER_CHECKSUM_EN, all coefficients 0 -> 27 bytes, last byte A5^00=A5.
